// File: rtl/axis_rr_input_arbiter_pkg.sv
// Shared AXIS arbiter definitions: FSM state encoding, counter width and index-width helper.
package axis_rr_input_arbiter_pkg;

    localparam int unsigned PKT_CNT_W = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Width of an index into n items; at least one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_input_arbiter_rr_priority_sel.sv
// Round-robin selector: first requester after last_idx, searching upward with wrap.
module rr_priority_sel #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   next_idx,
    output logic               valid
);

    logic [IDX_W:0] cand;

    // Candidate index stays below NUM_REQ with a single conditional subtract.
    always_comb begin
        next_idx = '0;
        valid    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = {1'b0, last_idx} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid    = 1'b1;
                next_idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_rr_input_arbiter.sv
// Packet-level round-robin AXI-Stream input arbiter: locks onto one input per packet,
// passes the granted stream through with zero latency and counts packets per input.
module axis_rr_input_arbiter
    import axis_rr_input_arbiter_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH = 64,
    parameter int unsigned C_AXIS_USER_WIDTH = 128,
    parameter int unsigned NUM_INPUTS        = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_INPUTS*C_AXIS_USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_INPUTS-1:0]                     s_axis_tvalid,
    input  logic [NUM_INPUTS-1:0]                     s_axis_tlast,
    output logic [NUM_INPUTS-1:0]                     s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
    output logic [C_AXIS_USER_WIDTH-1:0]              m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    input  logic [NUM_INPUTS-1:0]                     port_enable,
    output logic [NUM_INPUTS*PKT_CNT_W-1:0]           pkt_cnt,
    output logic [idx_w(NUM_INPUTS)-1:0]              grant_idx
);

    localparam int unsigned DW    = C_AXIS_DATA_WIDTH;
    localparam int unsigned SW    = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW    = C_AXIS_USER_WIDTH;
    localparam int unsigned IDX_W = idx_w(NUM_INPUTS);

    arb_state_t                               state;
    arb_state_t                               next_state;
    logic [NUM_INPUTS-1:0]                    req;
    logic [IDX_W-1:0]                         sel_idx;
    logic                                     sel_valid;
    logic                                     xfer_last;
    logic [NUM_INPUTS-1:0][PKT_CNT_W-1:0]     cnt;

    // Enable only gates new grants; a locked packet runs to completion regardless.
    assign req     = s_axis_tvalid & port_enable;
    assign pkt_cnt = cnt;

    rr_priority_sel #(
        .NUM_REQ (NUM_INPUTS),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req      (req),
        .last_idx (grant_idx),
        .next_idx (sel_idx),
        .valid    (sel_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the combinational pass-through mux of the granted slice.
    always_comb begin
        next_state    = state;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        xfer_last     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    next_state = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                    if (grant_idx == IDX_W'(i)) begin
                        m_axis_tdata     = s_axis_tdata[i*DW +: DW];
                        m_axis_tstrb     = s_axis_tstrb[i*SW +: SW];
                        m_axis_tuser     = s_axis_tuser[i*UW +: UW];
                        m_axis_tvalid    = s_axis_tvalid[i];
                        m_axis_tlast     = s_axis_tlast[i];
                        s_axis_tready[i] = m_axis_tready;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (reset) begin
            m_axis_tvalid = 1'b0;
            s_axis_tready = '0;
        end
        xfer_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        if (xfer_last) begin
            next_state = ST_IDLE;
        end
    end

    // Grant index resets to the last input so input 0 has first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_idx <= IDX_W'(NUM_INPUTS - 1);
            cnt       <= '0;
        end else begin
            if (state == ST_IDLE && sel_valid) begin
                grant_idx <= sel_idx;
            end
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                if (xfer_last && grant_idx == IDX_W'(i)) begin
                    cnt[i] <= cnt[i] + PKT_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_rr_input_arbiter.sv
// Scoreboard bench for axis_rr_input_arbiter: directed packets, expected beats queued in grant order.
module tb_axis_rr_input_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned UW = 128;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [7:0]    port;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N*DW-1:0]   s_tdata = '0;
    logic [N*SW-1:0]   s_tstrb = '0;
    logic [N*UW-1:0]   s_tuser = '0;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tlast = '0;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b1;
    logic [N-1:0]      port_enable = '1;
    logic [N*32-1:0]   pkt_cnt;
    logic [IW-1:0]     grant_idx;

    always #5 clk = ~clk;

    axis_rr_input_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_USER_WIDTH (UW),
        .NUM_INPUTS        (N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .port_enable   (port_enable),
        .pkt_cnt       (pkt_cnt),
        .grant_idx     (grant_idx)
    );

    int           errors = 0;
    int           checks = 0;
    beat_t        sb[$];
    beat_t        src_q[N][$];
    logic [N-1:0] acc = '0;
    bit           toggle_rdy = 1'b0;
    bit           bubble_due = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        return pkt_cnt[i*32 +: 32];
    endfunction

    function automatic beat_t mk_beat(input int p, input int k, input int b, input bit last);
        beat_t x;
        x.port = 8'(p);
        x.data = {16'hDA7A, 8'(p), 8'(k), 32'(b)};
        x.user = {~x.data, x.data};
        x.strb = 8'hF0 | 8'(b);
        x.last = last;
        return x;
    endfunction

    // Queue a packet on input p; the first n_exp beats are expected on the master port.
    task automatic push_pkt(input int p, input int k, input int nbeats, input int n_exp);
        for (int b = 0; b < nbeats; b++) begin
            src_q[p].push_back(mk_beat(p, k, b, b == nbeats - 1));
            if (b < n_exp) sb.push_back(mk_beat(p, k, b, b == nbeats - 1));
        end
    endtask

    task automatic wait_sb(input int target, input string name, input int budget);
        int n = 0;
        while (sb.size() > target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d beats outstanding, required %0d", name, sb.size(), target);
            sb.delete();
        end
    endtask

    task automatic flush_src();
        for (int i = 0; i < int'(N); i++) src_q[i].delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        flush_src();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Source drivers: retire beats accepted on the last edge, present the next one.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < int'(N); i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = src_q[i][0].data;
                s_tuser[i*UW +: UW]  = src_q[i][0].user;
                s_tstrb[i*SW +: SW]  = src_q[i][0].strb;
                s_tlast[i]           = src_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        m_tready = toggle_rdy ? ~m_tready : 1'b1;
    end

    always @(negedge clk) acc = s_tvalid & s_tready;

    // Monitor: compare every master-side transfer against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            logic [N-1:0] exp_rdy;
            beat_t        e;
            if (bubble_due) begin
                check("bubble_after_last", 256'(m_tvalid), 256'(0));
                bubble_due = 1'b0;
            end
            if (m_tvalid) begin
                exp_rdy = '0;
                exp_rdy[grant_idx] = m_tready;
                check("ready_route", 256'(s_tready), 256'(exp_rdy));
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h from port %0d, required no transfer", m_tdata, grant_idx);
                end else begin
                    e = sb.pop_front();
                    check("beat_port", 256'(grant_idx), 256'(e.port));
                    check("beat_data", 256'(m_tdata), 256'(e.data));
                    check("beat_user", 256'(m_tuser), 256'(e.user));
                    check("beat_strb", 256'(m_tstrb), 256'(e.strb));
                    check("beat_last", 256'(m_tlast), 256'(e.last));
                    if (m_tlast) bubble_due = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_hold_tvalid", 256'(m_tvalid), 256'(0));
        check("rst_hold_tready", 256'(s_tready), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 256'(m_tvalid), 256'(0));
        check("rst_grant_idx", 256'(grant_idx), 256'(3));
        check("rst_pkt_cnt", 256'(pkt_cnt), 256'(0));

        // Inputs 0 and 2 each offer a 3-beat packet: 0 first, then 2
        @(posedge clk);
        #1;
        push_pkt(0, 0, 3, 3);
        push_pkt(2, 0, 3, 3);
        wait_sb(0, "two_inputs", 100);
        repeat (2) @(negedge clk);
        check("two_cnt0", 256'(cnt_of(0)), 256'(1));
        check("two_cnt1", 256'(cnt_of(1)), 256'(0));
        check("two_cnt2", 256'(cnt_of(2)), 256'(1));
        check("two_cnt3", 256'(cnt_of(3)), 256'(0));

        // All four inputs, two 1-beat packets each: order 0,1,2,3,0,1,2,3
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < int'(N); p++) push_pkt(p, k, 1, 1);
        wait_sb(0, "rr_all", 200);
        repeat (2) @(negedge clk);
        for (int p = 0; p < int'(N); p++) check("rr_cnt", 256'(cnt_of(p)), 256'(2));

        // 5-beat packet on input 1 with toggling downstream ready
        do_reset();
        toggle_rdy = 1'b1;
        push_pkt(1, 0, 5, 5);
        wait_sb(0, "toggle_rdy", 100);
        toggle_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("toggle_cnt1", 256'(cnt_of(1)), 256'(1));

        // Input 1 disabled; input 0 enable dropped mid-packet still completes
        do_reset();
        port_enable = 4'b1101;
        toggle_rdy  = 1'b1;
        push_pkt(0, 0, 4, 4);
        push_pkt(1, 0, 1, 0);
        wait_sb(3, "en_first_beat", 100);
        #1;
        port_enable = 4'b1100;
        wait_sb(0, "en_complete", 100);
        repeat (10) @(posedge clk);
        toggle_rdy = 1'b0;
        @(negedge clk);
        check("en_cnt0", 256'(cnt_of(0)), 256'(1));
        check("en_cnt1", 256'(cnt_of(1)), 256'(0));
        check("en_idle_tvalid", 256'(m_tvalid), 256'(0));
        port_enable = '1;

        // Counter wrap from 0xFFFFFFFF
        do_reset();
        force dut.cnt = {96'h0, 32'hFFFF_FFFF};
        @(negedge clk);
        release dut.cnt;
        push_pkt(0, 0, 2, 2);
        wait_sb(0, "wrap", 100);
        repeat (2) @(negedge clk);
        check("wrap_cnt0", 256'(cnt_of(0)), 256'(0));
        check("wrap_cnt1", 256'(cnt_of(1)), 256'(0));

        // Reset on beat 2 of 4 abandons the packet
        do_reset();
        push_pkt(0, 0, 4, 1);
        wait_sb(0, "midrst_beat1", 100);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tvalid", 256'(m_tvalid), 256'(0));
        check("midrst_tready", 256'(s_tready), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush_src();
        @(negedge clk);
        check("postrst_tvalid", 256'(m_tvalid), 256'(0));
        check("postrst_pkt_cnt", 256'(pkt_cnt), 256'(0));
        check("postrst_grant_idx", 256'(grant_idx), 256'(3));
        push_pkt(0, 1, 1, 1);
        push_pkt(3, 1, 1, 1);
        wait_sb(0, "postrst_grant", 100);
        repeat (2) @(negedge clk);
        check("postrst_cnt0", 256'(cnt_of(0)), 256'(1));
        check("postrst_cnt3", 256'(cnt_of(3)), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

endmodule
